// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - five-state read/read/execute/writeback controller beside the 8x16 register file
module alu_sequencer #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          ready,
  input  logic [1:0]    op,
  input  logic [1:0]    shift,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  input  logic [RW-1:0] rd,
  input  logic          wb_en,
  output logic [RW-1:0] rf_readnum,
  input  logic [DW-1:0] rf_rdata,
  output logic [RW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          n,
  output logic          v,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

  state_t        state, state_nxt;
  logic [1:0]    op_q, shift_q;
  logic [RW-1:0] rn_q, rm_q, rd_q;
  logic          wb_en_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [DW-1:0] b_sh, c_nxt;
  logic          v_nxt;

  // Overflow is judged against the shifted operand, since that is what the adder sees.
  always_comb begin
    b_sh  = b_q;
    c_nxt = '0;
    v_nxt = 1'b0;
    case (shift_q)
      2'b01:   b_sh = {b_q[DW-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[DW-1:1]};
      2'b11:   b_sh = {b_q[DW-1], b_q[DW-1:1]};
      default: b_sh = b_q;
    endcase
    case (op_q)
      2'b00: begin
        c_nxt = a_q + b_sh;
        v_nxt = (a_q[DW-1] == b_sh[DW-1]) && (c_nxt[DW-1] != a_q[DW-1]);
      end
      2'b01: begin
        c_nxt = a_q - b_sh;
        v_nxt = (a_q[DW-1] != b_sh[DW-1]) && (c_nxt[DW-1] != a_q[DW-1]);
      end
      2'b10:   c_nxt = a_q & b_sh;
      default: c_nxt = ~b_sh;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    done        = 1'b0;
    rf_readnum  = '0;
    rf_writenum = '0;
    rf_write    = 1'b0;
    rf_wdata    = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RDA;
      end
      RDA: begin
        rf_readnum = rn_q;
        state_nxt  = RDB;
      end
      RDB: begin
        rf_readnum = rm_q;
        state_nxt  = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        rf_writenum = rd_q;
        rf_write    = wb_en_q;
        rf_wdata    = c_q;
        done        = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      shift_q <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z       <= 1'b0;
      n       <= 1'b0;
      v       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_q    <= op;
          shift_q <= shift;
          rn_q    <= rn;
          rm_q    <= rm;
          rd_q    <= rd;
          wb_en_q <= wb_en;
        end
        RDA: a_q <= rf_rdata;
        RDB: b_q <= rf_rdata;
        EXEC: begin
          c_q <= c_nxt;
          z   <= (c_nxt == '0);
          n   <= c_nxt[DW-1];
          v   <= v_nxt;
        end
        default: ;
      endcase
    end
  end

  assign result = c_q;

endmodule
